// File: rtl/uart_tx_sched_if.sv
// -----------------------------------------------------------------------------
// uart_tx_sched_if
// Bundles the two producer handshakes and the serialiser-facing outputs of
// uart_tx_sched.
//   slave  modport : used by uart_tx_sched (consumes requests, drives the UART side)
//   master modport : used by whatever drives the producers / observes the UART side
// Signals:
//   req0_valid_i / req0_data_i / req0_ready_o : producer 0 (CPU MMIO) byte handshake
//   req1_valid_i / req1_data_i / req1_ready_o : producer 1 (debug/trace) byte handshake
//   uart_write_o / uart_val_o                 : one-cycle load pulse + byte to serialiser
//   busy_o                                    : FIFO non-empty or frame in flight
//   level_o                                   : FIFO occupancy, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
interface uart_tx_sched_if #(
    parameter int DEPTH = 8
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             req0_valid_i;
    logic [7:0]       req0_data_i;
    logic             req0_ready_o;
    logic             req1_valid_i;
    logic [7:0]       req1_data_i;
    logic             req1_ready_o;
    logic             uart_write_o;
    logic [7:0]       uart_val_o;
    logic             busy_o;
    logic [LVL_W-1:0] level_o;

    modport slave (
        input  req0_valid_i, req0_data_i, req1_valid_i, req1_data_i,
        output req0_ready_o, req1_ready_o, uart_write_o, uart_val_o, busy_o, level_o
    );

    modport master (
        output req0_valid_i, req0_data_i, req1_valid_i, req1_data_i,
        input  req0_ready_o, req1_ready_o, uart_write_o, uart_val_o, busy_o, level_o
    );
endinterface

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
// Shares one TX serialiser between two byte producers. Accepted bytes are
// arbitrated round-robin into a DEPTH-entry FIFO and handed to the serialiser
// one frame at a time. The serialiser has no busy flag and restarts on every
// write, so this block spaces write pulses exactly FRAME cycles apart.
//
// Parameters:
//   FREQ  core clock in Hz
//   BAUD  line rate; DIV = FREQ/BAUD, FRAME = 10*(DIV+1) cycles per byte
//   DEPTH FIFO entries (power of 2, >= 2)
// Ports:
//   clk_i   core clock
//   rstn_i  asynchronous active-low reset (synchronous release expected upstream)
//   bus     uart_tx_sched_if.slave: producer handshakes, serialiser write/val,
//           busy_o and level_o
// Optional build:
//   UART_TX_SCHED_STATS_EN adds tx_count_o (write pulses, wrapping) and
//   stall_count_o (cycles with a request pending but nothing accepted,
//   saturating). Without the macro those ports and counters do not exist.
// -----------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int FREQ  = 27000000,
    parameter int BAUD  = 115200,
    parameter int DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    uart_tx_sched_if.slave    bus
`ifdef UART_TX_SCHED_STATS_EN
    ,
    output logic [15:0]       tx_count_o,
    output logic [15:0]       stall_count_o
`endif
);
    localparam int DIV   = FREQ / BAUD;
    localparam int FRAME = 10 * (DIV + 1);
    localparam int TMR_W = $clog2(FRAME) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             uart_write_q;
    logic [7:0]       uart_val_q;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             rr_prio1;   // 1: req1 wins a tie next time

    logic             pop;
    logic             full;
    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             push;
    logic [7:0]       push_data;
    logic [7:0]       head;

    // Arbitration: a slot frees up in the same cycle as a pop, so a full FIFO
    // can still accept while the write pulse is out. Ready is forced low while
    // reset is asserted so every output reads 0 during reset.
    assign pop        = uart_write_q;
    assign full       = (level == LVL_W'(DEPTH));
    assign can_accept = rstn_i & (~full | pop);
    assign grant0     = can_accept & bus.req0_valid_i & (~bus.req1_valid_i | ~rr_prio1);
    assign grant1     = can_accept & bus.req1_valid_i & ~grant0;
    assign push       = grant0 | grant1;
    assign push_data  = grant0 ? bus.req0_data_i : bus.req1_data_i;

    // With an empty FIFO the byte being accepted right now is the next to send;
    // this bypass gives the one-cycle accept-to-write latency.
    assign head = (level != '0) ? mem[rd_ptr] : push_data;

    // FIFO storage (data only, no reset)
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers, occupancy and round-robin pointer
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rr_prio1 <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                rr_prio1 <= grant0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Frame scheduler: the timer is loaded together with the write pulse, so
    // it reaches 0 in the last cycle of the frame and the next pulse (if any)
    // lands exactly FRAME cycles after the previous one.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= IDLE;
            timer        <= '0;
            uart_write_q <= 1'b0;
            uart_val_q   <= 8'h00;
        end else begin
            uart_write_q <= 1'b0;
            case (state)
                IDLE: begin
                    if ((level != '0) || push) begin
                        state        <= SEND;
                        uart_write_q <= 1'b1;
                        uart_val_q   <= head;
                        timer        <= TMR_W'(FRAME - 1);
                    end
                end
                SEND: begin
                    state <= WAIT;
                    timer <= timer - TMR_W'(1);
                end
                WAIT: begin
                    if (timer == '0) begin
                        if (level != '0) begin
                            state        <= SEND;
                            uart_write_q <= 1'b1;
                            uart_val_q   <= head;
                            timer        <= TMR_W'(FRAME - 1);
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready_o = grant0;
    assign bus.req1_ready_o = grant1;
    assign bus.uart_write_o = uart_write_q;
    assign bus.uart_val_o   = uart_val_q;
    assign bus.busy_o       = (state != IDLE) | (level != '0);
    assign bus.level_o      = level;

`ifdef UART_TX_SCHED_STATS_EN
    logic [15:0] tx_count;
    logic [15:0] stall_count;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_count    <= 16'h0000;
            stall_count <= 16'h0000;
        end else begin
            if (uart_write_q) begin
                tx_count <= tx_count + 16'd1;   // wraps at 0xFFFF
            end
            if ((bus.req0_valid_i | bus.req1_valid_i) && !push && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

    assign tx_count_o    = tx_count;
    assign stall_count_o = stall_count;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
// Bench for uart_tx_sched at FREQ=1152000, BAUD=115200 (FRAME=110), DEPTH=4.
// A transaction-level reference model (byte queue plus the time of the last
// write pulse) predicts ready, write, value, busy and level every cycle; a
// table of per-cycle vectors covers the both-valid arbitration start-up, and
// hand-written sequences cover latency, pacing, the full-FIFO pop cycle and
// reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;
    localparam int FREQ  = 1152000;
    localparam int BAUD  = 115200;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * (FREQ / BAUD + 1);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic clk_i  = 1'b0;
    logic rstn_i = 1'b0;

    uart_tx_sched_if #(.DEPTH(DEPTH)) bus ();

`ifdef UART_TX_SCHED_STATS_EN
    logic [15:0] tx_count_o;
    logic [15:0] stall_count_o;
`endif

    uart_tx_sched #(
        .FREQ  (FREQ),
        .BAUD  (BAUD),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .bus    (bus)
`ifdef UART_TX_SCHED_STATS_EN
        ,
        .tx_count_o    (tx_count_o),
        .stall_count_o (stall_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [14:0] outs();
        return {bus.req0_ready_o, bus.req1_ready_o, bus.uart_write_o,
                bus.uart_write_o ? bus.uart_val_o : 8'h00, bus.busy_o, bus.level_o};
    endfunction

    // ---------------- reference model ----------------
    logic       model_en = 1'b0;
    logic [7:0] mq[$];
    int         last_wr = -1000000;
    int         sched   = -1;
    bit         rr_m    = 1'b0;
    int         tx_e    = 0;
    int         stall_e = 0;

    task automatic model_step();
        int         lvl;
        bit         wnow, can, g0, g1, busy_e;
        logic [7:0] val_e;
        lvl    = mq.size();
        wnow   = (sched == cyc);
        can    = (lvl < DEPTH) || wnow;
        g0     = can && bus.req0_valid_i && (!bus.req1_valid_i || !rr_m);
        g1     = can && bus.req1_valid_i && !g0;
        busy_e = (cyc <= last_wr + FRAME - 1) || (lvl != 0);
        val_e  = (wnow && lvl > 0) ? mq[0] : 8'h00;
        check("model", {17'd0, outs()},
              {17'd0, g0, g1, wnow, val_e, busy_e, LVL_W'(lvl)});
`ifdef UART_TX_SCHED_STATS_EN
        check("tx_count", {16'd0, tx_count_o}, tx_e & 32'hFFFF);
        check("stall_count", {16'd0, stall_count_o}, stall_e);
`endif
        if (wnow) begin
            if (lvl > 0) void'(mq.pop_front());
            last_wr = cyc;
            tx_e++;
        end
        if ((bus.req0_valid_i || bus.req1_valid_i) && !g0 && !g1 && stall_e < 65535) stall_e++;
        if (g0) begin mq.push_back(bus.req0_data_i); rr_m = 1'b1; end
        if (g1) begin mq.push_back(bus.req1_data_i); rr_m = 1'b0; end
        // A byte is launched the cycle after the line becomes free with data
        // waiting; from a fully idle line an arriving byte counts as waiting.
        if (!wnow && sched < cyc) begin
            if (cyc >= last_wr + FRAME) begin
                if (lvl != 0 || g0 || g1) sched = cyc + 1;
            end else if (cyc == last_wr + FRAME - 1) begin
                if (lvl != 0) sched = cyc + 1;
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (model_en) begin
            if (!rstn_i) begin
                mq.delete();
                last_wr = -1000000;
                sched   = -1;
                rr_m    = 1'b0;
                tx_e    = 0;
                stall_e = 0;
                check("reset_outputs",
                      {17'd0, bus.req0_ready_o, bus.req1_ready_o, bus.uart_write_o,
                       bus.uart_val_o, bus.busy_o, bus.level_o}, 32'd0);
            end else begin
                model_step();
            end
        end
    end

    // Write-pulse log for the directed sequences
    int         wlog_c[$];
    logic [7:0] wlog_v[$];
    always @(negedge clk_i) begin
        if (rstn_i && bus.uart_write_o) begin
            wlog_c.push_back(cyc);
            wlog_v.push_back(bus.uart_val_o);
        end
    end

    // ---------------- table vectors ----------------
    typedef struct packed {
        logic             v0;
        logic [7:0]       d0;
        logic             v1;
        logic [7:0]       d1;
        logic             r0;
        logic             r1;
        logic             wr;
        logic [7:0]       val;
        logic             busy;
        logic [LVL_W-1:0] lvl;
    } vec_t;

    function automatic vec_t mk(input logic v0, input logic [7:0] d0, input logic v1,
                                input logic [7:0] d1, input logic r0, input logic r1,
                                input logic wr, input logic [7:0] val, input logic busy,
                                input int lvl);
        return {v0, d0, v1, d1, r0, r1, wr, val, busy, LVL_W'(lvl)};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (bus.busy_o && n < budget) begin
            tick();
            n++;
        end
        check(name, {31'd0, bus.busy_o}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        int   rel0, fall, t0, kk, full_rdy, rate0, rate1;

        // both producers valid every cycle from reset release
        tbl[0] = mk(1, 8'h10, 1, 8'h20, 1, 0, 0, 8'h00, 0, 0);
        tbl[1] = mk(1, 8'h11, 1, 8'h20, 0, 1, 1, 8'h10, 1, 1);
        tbl[2] = mk(1, 8'h11, 1, 8'h21, 1, 0, 0, 8'h00, 1, 1);
        tbl[3] = mk(1, 8'h12, 1, 8'h21, 0, 1, 0, 8'h00, 1, 2);
        tbl[4] = mk(1, 8'h12, 1, 8'h22, 1, 0, 0, 8'h00, 1, 3);
        tbl[5] = mk(1, 8'h13, 1, 8'h22, 0, 0, 0, 8'h00, 1, 4);
        tbl[6] = mk(1, 8'h13, 1, 8'h22, 0, 0, 0, 8'h00, 1, 4);

        bus.req0_valid_i = 1'b0;
        bus.req0_data_i  = 8'h00;
        bus.req1_valid_i = 1'b0;
        bus.req1_data_i  = 8'h00;
        rstn_i   = 1'b0;
        model_en = 1'b1;
        repeat (3) tick();
        rstn_i = 1'b1;
        rel0   = cyc;

        // single byte from idle: write next cycle, busy drops FRAME cycles later
        repeat (5) tick();
        bus.req0_valid_i = 1'b1;
        bus.req0_data_i  = 8'hA5;
        @(negedge clk_i);
        check("a5_accept", {31'd0, bus.req0_ready_o}, 32'd1);
        tick();
        bus.req0_valid_i = 1'b0;
        @(negedge clk_i);
        check("a5_write", {23'd0, bus.uart_write_o, bus.uart_val_o}, {23'd0, 1'b1, 8'hA5});
        fall = -1;
        for (int i = 0; i < 200; i++) begin
            tick();
            @(negedge clk_i);
            if (!bus.busy_o) begin
                fall = cyc - rel0;
                break;
            end
        end
        check("a5_busy_fall", fall, 116);

        // back-to-back stream from one producer
        wlog_c.delete();
        wlog_v.delete();
        tick();
        t0 = cyc;
        for (int i = 1; i <= 3; i++) begin
            bus.req0_valid_i = 1'b1;
            bus.req0_data_i  = 8'(i);
            @(negedge clk_i);
            check("stream_accept", {31'd0, bus.req0_ready_o}, 32'd1);
            tick();
        end
        bus.req0_valid_i = 1'b0;
        wait_idle("stream_idle", 600);
        check("stream_nwr", wlog_c.size(), 3);
        if (wlog_c.size() == 3) begin
            check("stream_lat",  wlog_c[0] - t0, 1);
            check("stream_gap1", wlog_c[1] - wlog_c[0], FRAME);
            check("stream_gap2", wlog_c[2] - wlog_c[1], FRAME);
            check("stream_vals", {8'd0, wlog_v[0], wlog_v[1], wlog_v[2]}, 32'h00010203);
        end

        // round-robin fill from a fresh reset, table driven
        rstn_i = 1'b0;
        tick();
        tick();
        rstn_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.req0_valid_i = tbl[k].v0;
            bus.req0_data_i  = tbl[k].d0;
            bus.req1_valid_i = tbl[k].v1;
            bus.req1_data_i  = tbl[k].d1;
            @(negedge clk_i);
            check($sformatf("arb_row%0d", k), {17'd0, outs()},
                  {17'd0, tbl[k].r0, tbl[k].r1, tbl[k].wr, tbl[k].val, tbl[k].busy, tbl[k].lvl});
            if (k < 6) tick();
        end

        // full FIFO: nobody is accepted until the next pop cycle
        kk = 6;
        full_rdy = 0;
        do begin
            tick();
            @(negedge clk_i);
            kk++;
            if (!bus.uart_write_o && (bus.req0_ready_o || bus.req1_ready_o)) full_rdy++;
        end while (!bus.uart_write_o && kk < 300);
        check("full_no_ready", full_rdy, 0);
        check("pop_cycle", kk, 1 + FRAME);
        check("pop_val", {24'd0, bus.uart_val_o}, 32'h20);
        check("pop_accept", {30'd0, bus.req0_ready_o, bus.req1_ready_o}, 32'b01);
        check("pop_level", {29'd0, bus.level_o}, DEPTH);
        tick();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        @(negedge clk_i);
        check("push_pop_level", {29'd0, bus.level_o}, DEPTH);

        // reset 50 cycles into a frame with bytes still queued
        repeat (49) tick();
        bus.req0_valid_i = 1'b1;
        bus.req1_valid_i = 1'b1;
        rstn_i = 1'b0;
        #1;
        check("rst_async", {17'd0, bus.req0_ready_o, bus.req1_ready_o, bus.uart_write_o,
                            bus.uart_val_o, bus.busy_o, bus.level_o}, 32'd0);
        tick();
        tick();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        rstn_i = 1'b1;
        wlog_c.delete();
        wlog_v.delete();
        repeat (300) tick();
        check("no_wr_after_rst", wlog_c.size(), 0);
        bus.req1_valid_i = 1'b1;
        bus.req1_data_i  = 8'h5A;
        @(negedge clk_i);
        check("post_rst_accept", {31'd0, bus.req1_ready_o}, 32'd1);
        tick();
        bus.req1_valid_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_write", {23'd0, bus.uart_write_o, bus.uart_val_o}, {23'd0, 1'b1, 8'h5A});
        tick();
        wait_idle("post_rst_idle", 300);

        // randomized traffic against the model, with varying load
        for (int blk = 0; blk < 4; blk++) begin
            case (blk)
                0:       begin rate0 = 1; rate1 = 1; end
                1:       begin rate0 = 9; rate1 = 9; end
                2:       begin rate0 = 9; rate1 = 0; end
                default: begin rate0 = 4; rate1 = 6; end
            endcase
            for (int i = 0; i < 800; i++) begin
                tick();
                bus.req0_valid_i = ($urandom_range(0, 9) < rate0);
                bus.req1_valid_i = ($urandom_range(0, 9) < rate1);
                bus.req0_data_i  = 8'($urandom_range(0, 255));
                bus.req1_data_i  = 8'($urandom_range(0, 255));
                rstn_i = (blk != 3) || ($urandom_range(0, 399) != 0);
            end
        end
        tick();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        rstn_i = 1'b1;
        wait_idle("final_idle", 2000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
